serial_adder: RTL and testbench

//   Digit-serial N-bit adder: generalises the 2-bit combinational adder to any

---
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial WIDTH-bit adder with start/busy/done handshake (optional SERIAL_ADDER_SUB_EN)
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] res_next;

    // Subtraction is addition of the inverted B with the inverted carry-in.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff   = b ^ {WIDTH{sub}};
    assign cin_eff = cin ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // One digit slice of the add, and the result register with the new digit entering at the top.
    always_comb begin
        dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res_next = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Handshake FSM and digit datapath; sum/cout load only on the final digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_eff;
                        carry <= cin_eff;
                        res   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= dsum[DIGIT];
                    res   <= res_next;
                    if (cnt == LAST) begin
                        sum_q  <= res_next;
                        cout_q <= dsum[DIGIT];
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       st2, c2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic       st8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       st84, c84, busy84, done84, cout84;
    logic [7:0] a84, b84, sum84;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub2, sub8, sub84;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(2), .DIGIT(1)) u_w2 (
        .clk(clk), .reset(reset), .start(st2), .a(a2), .b(b2), .cin(c2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub2),
`endif
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk(clk), .reset(reset), .start(st8), .a(a8), .b(b8), .cin(c8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .reset(reset), .start(st84), .a(a84), .b(b84), .cin(c84),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub84),
`endif
        .busy(busy84), .done(done84), .sum(sum84), .cout(cout84)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic dn(input int k);
        case (k)
            0:       return done2;
            1:       return done8;
            default: return done84;
        endcase
    endfunction

    task automatic launch(input int k, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        case (k)
            0: begin a2 = av[1:0]; b2 = bv[1:0]; c2 = cv; st2 = 1'b1; end
            1: begin a8 = av; b8 = bv; c8 = cv; st8 = 1'b1; end
            default: begin a84 = av; b84 = bv; c84 = cv; st84 = 1'b1; end
        endcase
    endtask

    task automatic drop();
        st2  = 1'b0;
        st8  = 1'b0;
        st84 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (dn(k)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_done(input int k, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (dn(k)) n++;
        end
    endtask

    initial begin
        int lat;
        int n;
        reset = 1'b1;
        drop();
        a2 = '0; b2 = '0; c2 = 1'b0;
        a8 = '0; b8 = '0; c8 = 1'b0;
        a84 = '0; b84 = '0; c84 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub2 = 1'b0; sub8 = 1'b0; sub84 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum",  32'(sum8),  32'd0);
        check("rst_cout", 32'(cout8), 32'd0);

        // Exhaustive 2-bit sweep
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                for (int c = 0; c < 2; c++) begin
                    launch(0, 8'(x), 8'(y), c[0]);
                    step();
                    drop();
                    wait_done(0, lat);
                    check("w2_lat", 32'(lat), 32'd2);
                    check("w2_res", 32'({cout2, sum2}), 32'(x + y + c));
                end
            end
        end

        // 8-bit, one bit per cycle
        launch(1, 8'hFF, 8'h01, 1'b0);
        step();
        drop();
        wait_done(1, lat);
        check("w8_lat", 32'(lat), 32'd8);
        check("w8_sum_ff01", 32'(sum8), 32'h00);
        check("w8_cout_ff01", 32'(cout8), 32'd1);
        step();
        check("w8_done_pulse", 32'(done8), 32'd0);
        launch(1, 8'h5A, 8'h33, 1'b1);
        step();
        drop();
        wait_done(1, lat);
        check("w8_lat2", 32'(lat), 32'd8);
        check("w8_sum_5a33", 32'(sum8), 32'h8E);
        check("w8_cout_5a33", 32'(cout8), 32'd0);

        // 8-bit, four bits per cycle, start held high
        launch(2, 8'h9C, 8'h7B, 1'b0);
        step();
        wait_done(2, lat);
        check("d4_lat", 32'(lat), 32'd2);
        check("d4_sum", 32'(sum84), 32'h17);
        check("d4_cout", 32'(cout84), 32'd1);
        wait_done(2, lat);
        check("d4_held_lat", 32'(lat), 32'd3);
        check("d4_held_sum", 32'(sum84), 32'h17);
        drop();

        // Start during BUSY is ignored
        launch(1, 8'h10, 8'h20, 1'b0);
        step();
        drop();
        check("ign_busy", 32'(busy8), 32'd1);
        check("ign_hold_sum", 32'(sum8), 32'h8E);
        step();
        step();
        launch(1, 8'h01, 8'h01, 1'b0);
        step();
        drop();
        wait_done(1, lat);
        check("ign_lat", 32'(lat), 32'd5);
        check("ign_sum", 32'(sum8), 32'h30);
        check("ign_cout", 32'(cout8), 32'd0);
        count_done(1, 12, n);
        check("ign_extra_done", 32'(n), 32'd0);

        // Reset mid-operation aborts it
        launch(1, 8'hFF, 8'h01, 1'b0);
        step();
        drop();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'h00);
        check("abort_cout", 32'(cout8), 32'd0);
        count_done(1, 12, n);
        check("abort_no_done", 32'(n), 32'd0);
        launch(1, 8'h5A, 8'h33, 1'b1);
        step();
        drop();
        wait_done(1, lat);
        check("post_lat", 32'(lat), 32'd8);
        check("post_sum", 32'(sum8), 32'h8E);
        check("post_cout", 32'(cout8), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b1;
        launch(1, 8'h10, 8'h01, 1'b0);
        step();
        drop();
        wait_done(1, lat);
        check("sub_sum_1001", 32'(sum8), 32'h0F);
        check("sub_cout_1001", 32'(cout8), 32'd1);
        launch(1, 8'h00, 8'h01, 1'b0);
        step();
        drop();
        wait_done(1, lat);
        check("sub_sum_0001", 32'(sum8), 32'hFF);
        check("sub_cout_0001", 32'(cout8), 32'd0);
        sub8 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
